// File: rtl/tour_pkg.sv
// Shared types and constants for the Knight tour command sequencer.
package tour_pkg;

    localparam logic [3:0] OP_CAL     = 4'h2;
    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_FANFARE = 4'h5;

    localparam logic [7:0] POS_ACK = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_DONE,
        S_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_BADCMD  = 2'd3
    } err_code_t;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == OP_CAL) || (op == OP_MOVE) || (op == OP_FANFARE);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry a wrap bit, flags are registered.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_nxt = wr_ptr + (AW+1)'(do_push);
        rd_nxt = rd_ptr + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    // Storage is data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tour_cmd_seq.sv
// Queues Knight commands and issues them one at a time, waiting for a positive
// acknowledge (or a NACK / timeout / bad opcode) before moving on.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TMO_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_cmd,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  n_acked
);

    // Counter runs 0 in SEND, so reaching this value means the next count is terminal.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    seq_state_t       state;
    err_code_t        ec;
    logic [TMO_W-1:0] tmo;
    logic [15:0]      fifo_dout;
    logic             fifo_pop;

    assign fifo_pop = (state == S_POP) && !abort;
    assign err_code = ec;

    cmd_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_cmd),
        .pop   (fifo_pop),
        .flush (abort),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd      <= '0;
            send_cmd <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ec       <= ERR_NONE;
            n_acked  <= '0;
            busy     <= 1'b0;
            tmo      <= '0;
        end else begin
            send_cmd <= 1'b0;
            done     <= 1'b0;
            if (state inside {S_SEND, S_WAIT_SENT, S_WAIT_RESP})
                tmo <= tmo + TMO_W'(1);

            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                err   <= 1'b0;
                ec    <= ERR_NONE;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (start) begin
                            n_acked <= '0;
                            err     <= 1'b0;
                            ec      <= ERR_NONE;
                            busy    <= 1'b1;
                            state   <= empty ? S_DONE : S_POP;
                            done    <= empty;
                        end
                    end
                    S_POP: begin
                        cmd <= fifo_dout;
                        if (is_valid_op(fifo_dout[15:12])) begin
                            state    <= S_SEND;
                            send_cmd <= 1'b1;
                            tmo      <= '0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            ec    <= ERR_BADCMD;
                        end
                    end
                    S_SEND: state <= S_WAIT_SENT;
                    S_WAIT_SENT: begin
                        if (cmd_sent) begin
                            state <= S_WAIT_RESP;
                        end else if (tmo >= TMO_LAST) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            ec    <= ERR_TIMEOUT;
                        end
                    end
                    // A response in the terminal-count cycle wins over the timeout.
                    S_WAIT_RESP: begin
                        if (resp_rdy) begin
                            if (resp == POS_ACK) begin
                                if (n_acked != 8'hFF)
                                    n_acked <= n_acked + 8'd1;
                                state <= empty ? S_DONE : S_POP;
                                done  <= empty;
                            end else begin
                                state <= S_ERR;
                                err   <= 1'b1;
                                ec    <= ERR_NACK;
                            end
                        end else if (tmo >= TMO_LAST) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            ec    <= ERR_TIMEOUT;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq against a queue-based reference model.
module tb_tour_cmd_seq;

    localparam int DEPTH = 4;
    localparam int TMO_W = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wr_cmd = 1'b0, start = 1'b0, abort = 1'b0;
    logic        cmd_sent = 1'b0, resp_rdy = 1'b0;
    logic [15:0] wr_data = '0;
    logic [7:0]  resp = '0;
    logic        full, empty, send_cmd, busy, done, err;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [7:0]  n_acked;

    int checks = 0, failures = 0;
    int send_cnt = 0, done_cnt = 0;
    logic [15:0] model_q[$];

    tour_cmd_seq #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .full(full), .empty(empty), .start(start), .abort(abort),
        .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .n_acked(n_acked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (send_cmd) send_cnt <= send_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit op_ok(input logic [15:0] c);
        return (c[15:12] == 4'h2) || (c[15:12] == 4'h4) || (c[15:12] == 4'h5);
    endfunction

    function automatic logic [15:0] rand_cmd(input bit valid);
        logic [3:0] op;
        logic [15:0] c;
        if (valid) begin
            case ($urandom_range(0, 2))
                0:       op = 4'h2;
                1:       op = 4'h4;
                default: op = 4'h5;
            endcase
        end else begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'h2 || op == 4'h4 || op == 4'h5);
        end
        c = {op, 12'($urandom)};
        return c;
    endfunction

    task automatic push(input logic [15:0] c);
        wr_cmd = 1'b1; wr_data = c;
        tick();
        wr_cmd = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(c);
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; tick(); abort = 1'b0;
        model_q.delete();
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (send_cmd) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_err(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (err) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Act as RemoteComm_e plus the Knight: see the launch, finish the UART, reply.
    task automatic serve(input logic [15:0] exp_cmd, input logic [7:0] r, input int dly);
        bit ok;
        int d1, d2;
        d1 = (dly < 0) ? $urandom_range(0, 3) : dly;
        d2 = (dly < 0) ? $urandom_range(0, 3) : dly;
        wait_send(ok);
        chk("send_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("cmd", 32'(cmd), 32'(exp_cmd));
        repeat (d1 + 1) tick();
        cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
        repeat (d2) tick();
        resp = r; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
    endtask

    initial begin
        bit ok;
        int base, base_done, k, n, acked;
        logic [15:0] c;

        repeat (3) tick();
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_send", 32'(send_cmd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_nack", 32'(n_acked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        rst_n = 1'b1;
        tick();

        // Two-command tour with latency and back-to-back timing.
        push(16'h2000); push(16'h4BF1);
        chk("two_empty0", 32'(empty), 32'd0);
        base = send_cnt;
        do_start();
        tick();
        chk("start_lat", 32'(send_cmd), 32'd1);
        serve(model_q.pop_front(), 8'hA5, 0);
        tick();
        chk("b2b_lat", 32'(send_cmd), 32'd1);
        serve(model_q.pop_front(), 8'hA5, -1);
        wait_done(ok);
        chk("two_done", 32'(ok), 32'd1);
        chk("two_nack", 32'(n_acked), 32'd2);
        chk("two_empty", 32'(empty), 32'd1);
        chk("two_sends", 32'(send_cnt - base), 32'd2);
        tick();
        chk("two_idle", 32'(busy), 32'd0);

        // NACK then resume from the retained entry.
        push(16'h57F2); push(16'h4001);
        do_start();
        serve(model_q.pop_front(), 8'h5A, -1);
        wait_err(ok);
        chk("nack_err", 32'(ok), 32'd1);
        chk("nack_code", 32'(err_code), 32'd1);
        chk("nack_retained", 32'(empty), 32'd0);
        chk("nack_busy", 32'(busy), 32'd1);
        chk("nack_cnt", 32'(n_acked), 32'd0);
        do_start();
        serve(model_q.pop_front(), 8'hA5, -1);
        wait_done(ok);
        chk("resume_done", 32'(ok), 32'd1);
        chk("resume_nack", 32'(n_acked), 32'd1);
        chk("resume_err", 32'(err), 32'd0);
        tick();

        // Timeout: cmd_sent arrives but no response ever does.
        push(16'h4123);
        do_start();
        wait_send(ok);
        chk("tmo_send", 32'(ok), 32'd1);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            cmd_sent = (i == 3);
            tick();
            if (err_code == 2'd2) begin k = i; break; end
        end
        cmd_sent = 1'b0;
        chk("tmo_cycles", 32'(k), 32'd255);
        chk("tmo_busy", 32'(busy), 32'd1);
        do_abort();
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);

        // Ack landing exactly on the terminal-count cycle is accepted.
        push(16'h5001);
        do_start();
        wait_send(ok);
        for (int i = 1; i <= 254; i++) begin
            cmd_sent = (i == 2);
            tick();
        end
        cmd_sent = 1'b0;
        resp = 8'hA5; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
        wait_done(ok);
        chk("tmo_edge_done", 32'(ok), 32'd1);
        chk("tmo_edge_err", 32'(err), 32'd0);
        chk("tmo_edge_nack", 32'(n_acked), 32'd1);
        void'(model_q.pop_front());
        tick();

        // Bad opcode is never launched.
        do_abort();
        push(16'h7000);
        base = send_cnt;
        do_start();
        wait_err(ok);
        chk("bad_err", 32'(ok), 32'd1);
        chk("bad_code", 32'(err_code), 32'd3);
        repeat (2) tick();
        chk("bad_nosend", 32'(send_cnt - base), 32'd0);
        chk("bad_cmd", 32'(cmd), 32'h7000);
        chk("bad_busy", 32'(busy), 32'd1);

        // Overfill a 4-deep FIFO.
        do_abort();
        for (int i = 0; i < 4; i++) push(rand_cmd(1'b1));
        chk("full_4", 32'(full), 32'd1);
        push(16'h2FFF);
        chk("full_5", 32'(full), 32'd1);
        chk("full_model", 32'(model_q.size()), 32'd4);
        base = send_cnt;
        do_start();
        while (model_q.size() > 0) serve(model_q.pop_front(), 8'hA5, -1);
        wait_done(ok);
        chk("full_done", 32'(ok), 32'd1);
        chk("full_sends", 32'(send_cnt - base), 32'd4);
        chk("full_nack", 32'(n_acked), 32'd4);
        chk("full_empty", 32'(empty), 32'd1);
        tick();

        // Abort while waiting for the response; late ack must be ignored.
        push(16'h4111); push(16'h4222);
        base = send_cnt;
        base_done = done_cnt;
        do_start();
        wait_send(ok);
        tick();
        cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
        tick();
        do_abort();
        resp = 8'hA5; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
        repeat (3) tick();
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_empty", 32'(empty), 32'd1);
        chk("ab_nack", 32'(n_acked), 32'd0);
        chk("ab_nodone", 32'(done_cnt - base_done), 32'd0);
        chk("ab_sends", 32'(send_cnt - base), 32'd1);
        chk("ab_err", 32'(err), 32'd0);

        // Randomized tours.
        for (int it = 0; it < 30; it++) begin
            bit failed;
            do_abort();
            chk("r_flush", 32'(empty), 32'd1);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push(rand_cmd($urandom_range(0, 9) != 0));
            base = send_cnt;
            acked = 0;
            failed = 1'b0;
            do_start();
            while (model_q.size() > 0 && !failed) begin
                c = model_q.pop_front();
                if (!op_ok(c)) begin
                    wait_err(ok);
                    chk("r_bad_err", 32'(ok), 32'd1);
                    chk("r_bad_code", 32'(err_code), 32'd3);
                    failed = 1'b1;
                end else if ($urandom_range(0, 9) == 0) begin
                    serve(c, 8'($urandom_range(0, 255)) ^ 8'h01 | 8'h00, -1);
                    if (resp == 8'hA5) begin
                        acked++;
                    end else begin
                        wait_err(ok);
                        chk("r_nack_code", 32'(err_code), 32'd1);
                        failed = 1'b1;
                    end
                end else begin
                    serve(c, 8'hA5, -1);
                    acked++;
                end
            end
            if (failed) begin
                repeat (2) tick();
                chk("r_err_busy", 32'(busy), 32'd1);
                chk("r_err_empty", 32'(empty), 32'(model_q.size() == 0));
            end else begin
                wait_done(ok);
                chk("r_done", 32'(ok), 32'd1);
                chk("r_empty", 32'(empty), 32'd1);
                repeat (2) tick();
            end
            chk("r_nack", 32'(n_acked), 32'(acked));
            chk("r_sends", 32'(send_cnt - base), 32'(acked + (failed && err_code == 2'd1 ? 1 : 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
